// File: rtl/switch_scheduler.sv
// switch_scheduler: matches pending core send/recv requests and grants one Switch transfer per cycle, round-robin by sender
//   clock, reset                 posedge clock, asynchronous active-high reset
//   send_ready, send_core_idx    per-core send request and its destination core
//   recv_request, recv_core_idx  per-core receive request and the source core it waits on
//   send_ok, recv_ready          one-cycle completion pulses for the granted sender/receiver
//   send_busy, recv_busy         per-core pending-request flags
//   grant_valid, grant_src/dst   registered grant and Switch mux selects (selects hold when idle)
//   idx_err                      one-cycle pulse when an out-of-range index is dropped
module switch_scheduler #(
    parameter int CORE_SIZE      = 3,
    parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [CORE_SIZE-1:0]                     send_ready,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] send_core_idx,
    input  logic [CORE_SIZE-1:0]                     recv_request,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic [CORE_SIZE-1:0]                     send_ok,
    output logic [CORE_SIZE-1:0]                     recv_ready,
    output logic [CORE_SIZE-1:0]                     send_busy,
    output logic [CORE_SIZE-1:0]                     recv_busy,
    output logic                                     grant_valid,
    output logic [CORE_ADDR_SIZE-1:0]                grant_src,
    output logic [CORE_ADDR_SIZE-1:0]                grant_dst,
    output logic                                     idx_err
);
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0] dst, src, partner;
    logic [CORE_SIZE-1:0][CORE_SIZE-1:0]      partner_oh;
    logic [CORE_SIZE-1:0]                     elig, send_bad, recv_bad, send_cap, recv_cap, win_s_oh, win_d_oh;
    logic [CORE_ADDR_SIZE-1:0]                rr_ptr, rr_next, win_s, win_d;
    logic                                     found, err_next;
    int                                       k;

    // Each sender has at most one eligible receiver, so partner[s] is unique when elig[s] is set.
    always_comb begin
        elig       = '0;
        partner    = '0;
        partner_oh = '0;
        send_bad   = '0;
        recv_bad   = '0;
        for (int s = 0; s < CORE_SIZE; s++) begin
            send_bad[s] = int'(send_core_idx[s]) >= CORE_SIZE;
            recv_bad[s] = int'(recv_core_idx[s]) >= CORE_SIZE;
            for (int d = 0; d < CORE_SIZE; d++) begin
                if (send_busy[s] && recv_busy[d] && dst[s] == CORE_ADDR_SIZE'(d) && src[d] == CORE_ADDR_SIZE'(s)) begin
                    elig[s]          = 1'b1;
                    partner[s]       = CORE_ADDR_SIZE'(d);
                    partner_oh[s][d] = 1'b1;
                end
            end
        end
    end

    // A requester whose busy bit is set (including the cycle it clears) is blocked.
    always_comb begin
        send_cap = send_ready & ~send_busy & ~send_bad;
        recv_cap = recv_request & ~recv_busy & ~recv_bad;
        err_next = |(send_ready & ~send_busy & send_bad) | |(recv_request & ~recv_busy & recv_bad);
    end

    always_comb begin
        found    = 1'b0;
        win_s    = '0;
        win_d    = '0;
        win_s_oh = '0;
        win_d_oh = '0;
        k        = 0;
        for (int i = 0; i < CORE_SIZE; i++) begin
            k = (int'(rr_ptr) + i) % CORE_SIZE;
            if (!found && elig[k]) begin
                found       = 1'b1;
                win_s       = CORE_ADDR_SIZE'(k);
                win_d       = partner[k];
                win_s_oh[k] = 1'b1;
                win_d_oh    = partner_oh[k];
            end
        end
        rr_next = (win_s == CORE_ADDR_SIZE'(CORE_SIZE - 1)) ? '0 : win_s + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dst         <= '0;
            src         <= '0;
            send_busy   <= '0;
            recv_busy   <= '0;
            send_ok     <= '0;
            recv_ready  <= '0;
            grant_valid <= 1'b0;
            grant_src   <= '0;
            grant_dst   <= '0;
            idx_err     <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            send_busy   <= (send_busy & ~win_s_oh) | send_cap;
            recv_busy   <= (recv_busy & ~win_d_oh) | recv_cap;
            send_ok     <= win_s_oh;
            recv_ready  <= win_d_oh;
            grant_valid <= found;
            idx_err     <= err_next;
            if (found) begin
                grant_src <= win_s;
                grant_dst <= win_d;
                rr_ptr    <= rr_next;
            end
            for (int s = 0; s < CORE_SIZE; s++) begin
                if (send_cap[s]) dst[s] <= send_core_idx[s];
                if (recv_cap[s]) src[s] <= recv_core_idx[s];
            end
        end
    end
endmodule

// File: tb/tb_switch_scheduler.sv
// tb_switch_scheduler: directed and random stimulus for switch_scheduler checked against a request-table model
module tb_switch_scheduler;
    localparam int N = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      send_ready, recv_request;
    logic [N-1:0][1:0] send_core_idx, recv_core_idx;
    logic [N-1:0]      send_ok, recv_ready, send_busy, recv_busy;
    logic              grant_valid, idx_err;
    logic [1:0]        grant_src, grant_dst;

    int n_cmp = 0;
    int n_err = 0;

    bit           m_sb[N];
    bit           m_rb[N];
    int           m_sd[N];
    int           m_rs[N];
    int           m_rr;
    logic [N-1:0] e_ok, e_rdy;
    logic         e_gv, e_err;
    int           e_gs, e_gd;

    switch_scheduler #(.CORE_SIZE(N)) dut (
        .clock(clock), .reset(reset),
        .send_ready(send_ready), .send_core_idx(send_core_idx),
        .recv_request(recv_request), .recv_core_idx(recv_core_idx),
        .send_ok(send_ok), .recv_ready(recv_ready),
        .send_busy(send_busy), .recv_busy(recv_busy),
        .grant_valid(grant_valid), .grant_src(grant_src), .grant_dst(grant_dst),
        .idx_err(idx_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sb[i] = 0; m_rb[i] = 0; m_sd[i] = 0; m_rs[i] = 0;
        end
        m_rr = 0; e_ok = '0; e_rdy = '0; e_gv = 0; e_err = 0; e_gs = 0; e_gd = 0;
    endtask

    // One clock edge of the scheduler described as request tables: a sender is served when
    // its target receiver waits on it; the search starts at the round-robin pointer.
    task automatic model_step();
        bit fnd = 0;
        int gs = 0;
        int gd = 0;
        bit cs[N];
        bit cr[N];
        for (int i = 0; i < N; i++) begin
            int s;
            s = (m_rr + i) % N;
            if (!fnd && m_sb[s] && m_rb[m_sd[s]] && m_rs[m_sd[s]] == s) begin
                fnd = 1; gs = s; gd = m_sd[s];
            end
        end
        e_err = 0;
        for (int i = 0; i < N; i++) begin
            cs[i] = send_ready[i] && !m_sb[i];
            cr[i] = recv_request[i] && !m_rb[i];
            if (cs[i] && int'(send_core_idx[i]) >= N) begin e_err = 1; cs[i] = 0; end
            if (cr[i] && int'(recv_core_idx[i]) >= N) begin e_err = 1; cr[i] = 0; end
        end
        e_ok = '0; e_rdy = '0; e_gv = fnd;
        if (fnd) begin
            m_sb[gs] = 0; m_rb[gd] = 0; m_rr = (gs + 1) % N;
            e_gs = gs; e_gd = gd; e_ok[gs] = 1'b1; e_rdy[gd] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (cs[i]) begin m_sb[i] = 1; m_sd[i] = int'(send_core_idx[i]); end
            if (cr[i]) begin m_rb[i] = 1; m_rs[i] = int'(recv_core_idx[i]); end
        end
    endtask

    task automatic check_all(input string p);
        logic [N-1:0] eb_s, eb_r;
        for (int i = 0; i < N; i++) begin eb_s[i] = m_sb[i]; eb_r[i] = m_rb[i]; end
        chk({p, ".send_ok"}, int'(send_ok), int'(e_ok));
        chk({p, ".recv_ready"}, int'(recv_ready), int'(e_rdy));
        chk({p, ".send_busy"}, int'(send_busy), int'(eb_s));
        chk({p, ".recv_busy"}, int'(recv_busy), int'(eb_r));
        chk({p, ".grant_valid"}, int'(grant_valid), int'(e_gv));
        chk({p, ".grant_src"}, int'(grant_src), e_gs);
        chk({p, ".grant_dst"}, int'(grant_dst), e_gd);
        chk({p, ".idx_err"}, int'(idx_err), int'(e_err));
    endtask

    task automatic tick(input string p);
        @(posedge clock);
        model_step();
        #1;
        check_all(p);
    endtask

    task automatic do_reset(input string p);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(p);
        reset = 1'b0;
    endtask

    task automatic idle();
        send_ready = '0; recv_request = '0; send_core_idx = '0; recv_core_idx = '0;
    endtask

    task automatic send(input int s, input int d);
        send_ready[s] = 1'b1; send_core_idx[s] = 2'(d);
    endtask

    task automatic recv(input int d, input int s);
        recv_request[d] = 1'b1; recv_core_idx[d] = 2'(s);
    endtask

    initial begin
        idle();
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b0;

        send(2, 1); tick("s1");
        idle(); repeat (3) tick("s1");
        chk("s1_wait_busy", int'(send_busy), 3'b100);
        recv(1, 2); tick("s1");
        chk("s1_cap_gv", int'(grant_valid), 0);
        idle(); tick("s1");
        chk("s1_gv", int'(grant_valid), 1);
        chk("s1_src", int'(grant_src), 2);
        chk("s1_dst", int'(grant_dst), 1);
        chk("s1_ok", int'(send_ok), 3'b100);
        chk("s1_rdy", int'(recv_ready), 3'b010);
        tick("s1");
        chk("s1_after_gv", int'(grant_valid), 0);
        chk("s1_hold_src", int'(grant_src), 2);

        send(1, 0); tick("s2");
        recv(0, 1); tick("s2");
        chk("s2_busy", int'({send_busy, recv_busy}), 6'b010_001);
        send_ready[1] = 1'b0; tick("s2");
        chk("s2_gv", int'(grant_valid), 1);
        chk("s2_src", int'(grant_src), 1);
        chk("s2_dst", int'(grant_dst), 0);
        tick("s2");
        chk("s2_recapture", int'(recv_busy), 3'b001);
        chk("s2_single_grant", int'(grant_valid), 0);
        idle(); tick("s2");

        do_reset("s6_reset");
        chk("s6_async_busy", int'({send_busy, recv_busy}), 0);
        send(1, 0); tick("s6");
        idle(); tick("s6");
        chk("s6_no_grant", int'(grant_valid), 0);
        tick("s6");
        do_reset("s6_reset2");

        for (int r = 0; r < 2; r++) begin
            idle(); send(0, 2); send(2, 0); tick("s3");
            idle(); recv(2, 0); recv(0, 2); tick("s3");
            idle(); tick("s3");
            chk("s3_first_src", int'(grant_src), 0);
            chk("s3_first_dst", int'(grant_dst), 2);
            tick("s3");
            chk("s3_second_src", int'(grant_src), 2);
            chk("s3_second_dst", int'(grant_dst), 0);
            tick("s3");
            chk("s3_done_gv", int'(grant_valid), 0);
        end

        send(0, 3); tick("s4");
        chk("s4_err", int'(idx_err), 1);
        chk("s4_busy", int'(send_busy), 0);
        idle(); tick("s4");
        chk("s4_err_clear", int'(idx_err), 0);

        recv(1, 2); tick("s5");
        idle(); tick("s5"); tick("s5");
        send(2, 1); tick("s5");
        idle(); tick("s5");
        chk("s5_gv", int'(grant_valid), 1);
        chk("s5_pair", int'({grant_src, grant_dst}), 4'b10_01);

        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 59) do_reset("rand_reset");
            for (int i = 0; i < N; i++) begin
                send_ready[i]    = ($urandom_range(0, 2) == 0);
                recv_request[i]  = ($urandom_range(0, 2) == 0);
                send_core_idx[i] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                recv_core_idx[i] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            tick("rand");
        end
        idle(); tick("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
